// File: rtl/pll_reconfig_sequencer.sv
// Initiator side of the PLL reconfiguration handshake: validates M/N requests, drives the
// factors and the trigger pulse, tracks busy/lock and returns one status per request.
module pll_reconfig_sequencer #(
  parameter int unsigned TRIG_CYCLES  = 5,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned DONE_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_mult,
  input  logic [7:0] i_req_div,
  output logic       o_resp_valid,
  output logic [1:0] o_resp_status,
  output logic [7:0] o_pll_mult,
  output logic [7:0] o_pll_div,
  output logic       o_pll_trigger,
  input  logic       i_pll_busy,
  input  logic       i_pll_locked,
  output logic [7:0] o_cur_mult,
  output logic [7:0] o_cur_div
);

  localparam int unsigned FW     = 8;
  localparam int unsigned SW     = 2;
  localparam int unsigned MAX_A  = (TRIG_CYCLES > SETUP_CYCLES) ? TRIG_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_B  = (BUSY_TIMEOUT > DONE_TIMEOUT) ? BUSY_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MAX = (MAX_C > LOCK_TIMEOUT) ? MAX_C : LOCK_TIMEOUT;
  localparam int unsigned CW     = $clog2(CNT_MAX + 1);
  localparam int unsigned LCW    = $clog2(LOCK_STABLE + 2);
  localparam int unsigned RCW    = $clog2(MAX_RETRY + 2);

  localparam logic [SW-1:0] ST_OK       = 2'd0;
  localparam logic [SW-1:0] ST_BAD_ARGS = 2'd1;
  localparam logic [SW-1:0] ST_BUSY_TO  = 2'd2;
  localparam logic [SW-1:0] ST_LOCK_TO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ARM, S_TRIG, S_WAIT_BUSY, S_WAIT_DONE, S_WAIT_LOCK
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [LCW-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic [RCW-1:0]  r_retry, w_retry_nxt;
  logic [FW-1:0]   r_req_mult, r_req_div;
  logic [FW-1:0]   r_pll_mult, r_pll_div, r_cur_mult, r_cur_div;
  logic            r_lock_meta, r_lock_sync;
  logic            r_req_ready, r_resp_valid, r_trig;
  logic [SW-1:0]   r_resp_status, w_status;
  logic            w_accept, w_resp, w_load_pll, w_ok, w_stable;
  state_t          w_arm_target;

  assign w_accept     = i_req_valid && r_req_ready;
  assign w_stable     = r_lock_sync && (r_lock_cnt == LCW'(LOCK_STABLE - 1));
  assign w_arm_target = (SETUP_CYCLES == 0) ? S_TRIG : S_ARM;

  // Next-state and per-state counters
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lock_cnt_nxt = '0;
    w_retry_nxt    = r_retry;
    w_resp         = 1'b0;
    w_status       = r_resp_status;
    w_load_pll     = 1'b0;
    w_ok           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_retry_nxt = '0;
        w_cnt_nxt   = '0;
        if (w_accept) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_cnt_nxt = '0;
        if ((r_req_mult == '0) || (r_req_div == '0)) begin
          w_state_nxt = S_IDLE;
          w_resp      = 1'b1;
          w_status    = ST_BAD_ARGS;
        end else begin
          w_load_pll  = 1'b1;
          w_state_nxt = w_arm_target;
        end
      end
      S_ARM: begin
        if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
          w_state_nxt = S_TRIG;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_TRIG: begin
        if (r_cnt == CW'(TRIG_CYCLES - 1)) begin
          w_state_nxt = S_WAIT_BUSY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (i_pll_busy) begin
          w_state_nxt = S_WAIT_DONE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_resp      = 1'b1;
          w_status    = ST_BUSY_TO;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!i_pll_busy) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(DONE_TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_resp      = 1'b1;
          w_status    = ST_BUSY_TO;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock qualification is checked ahead of the timeout so it wins a tie
        w_lock_cnt_nxt = r_lock_sync ? (r_lock_cnt + LCW'(1)) : '0;
        if (w_stable) begin
          w_state_nxt = S_IDLE;
          w_resp      = 1'b1;
          w_status    = ST_OK;
          w_ok        = 1'b1;
        end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          w_cnt_nxt = '0;
          if (r_retry < RCW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RCW'(1);
            w_state_nxt = w_arm_target;
          end else begin
            w_state_nxt = S_IDLE;
            w_resp      = 1'b1;
            w_status    = ST_LOCK_TO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_lock_cnt    <= '0;
      r_retry       <= '0;
      r_req_mult    <= FW'(1);
      r_req_div     <= FW'(1);
      r_pll_mult    <= FW'(1);
      r_pll_div     <= FW'(1);
      r_cur_mult    <= FW'(1);
      r_cur_div     <= FW'(1);
      r_lock_meta   <= 1'b0;
      r_lock_sync   <= 1'b0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
      r_trig        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_lock_meta  <= i_pll_locked;
      r_lock_sync  <= r_lock_meta;
      // Ready only after a full idle cycle, so never alongside resp_valid
      r_req_ready  <= (r_state == S_IDLE) && (w_state_nxt == S_IDLE);
      r_resp_valid <= w_resp;
      r_trig       <= (w_state_nxt == S_TRIG);
      if (w_resp) r_resp_status <= w_status;
      if (w_accept) begin
        r_req_mult <= i_req_mult;
        r_req_div  <= i_req_div;
      end
      if (w_load_pll) begin
        r_pll_mult <= r_req_mult;
        r_pll_div  <= r_req_div;
      end
      if (w_ok) begin
        r_cur_mult <= r_pll_mult;
        r_cur_div  <= r_pll_div;
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_status = r_resp_status;
  assign o_pll_mult    = r_pll_mult;
  assign o_pll_div     = r_pll_div;
  assign o_pll_trigger = r_trig;
  assign o_cur_mult    = r_cur_mult;
  assign o_cur_div     = r_cur_div;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for pll_reconfig_sequencer with a small behavioural PLL (busy/lock) model.
module tb_pll_reconfig_sequencer;

  logic       clk = 1'b0;
  logic       rst, valid;
  logic [7:0] mult, div;
  logic       ready, resp_valid, trig;
  logic [1:0] status;
  logic [7:0] pll_mult, pll_div, cur_mult, cur_div;
  logic       busy = 1'b0;
  logic       locked = 1'b1;

  int total = 0;
  int bad = 0;

  // PLL model configuration, written by the stimulus thread between requests
  bit busy_en   = 1'b1;
  int busy_len  = 20;
  int lock_mode = 0;
  logic trig_q  = 1'b0;
  int bcnt = 0;
  int tcnt = 0;

  pll_reconfig_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_mult(mult), .i_req_div(div), .o_resp_valid(resp_valid), .o_resp_status(status),
    .o_pll_mult(pll_mult), .o_pll_div(pll_div), .o_pll_trigger(trig),
    .i_pll_busy(busy), .i_pll_locked(locked), .o_cur_mult(cur_mult), .o_cur_div(cur_div)
  );

  always #5 clk = ~clk;

  // Busy rises when trigger falls and lasts busy_len cycles; lock_mode 0 steady,
  // 1 drops lock while busy, 2 toggles every 10 cycles
  always @(negedge clk) begin
    if (!busy_en) busy = 1'b0;
    else if (trig_q && !trig) begin
      busy = 1'b1;
      bcnt = busy_len;
      if (lock_mode == 1) locked = 1'b0;
    end else if (busy && bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        busy = 1'b0;
        if (lock_mode == 1) locked = 1'b1;
      end
    end
    if (lock_mode == 0) locked = 1'b1;
    else if (lock_mode == 2) begin
      tcnt++;
      if (tcnt >= 10) begin
        tcnt = 0;
        locked = ~locked;
      end
    end
    trig_q = trig;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request; cycle 0 is the accept cycle, lat is the resp_valid cycle
  task automatic run_req(input logic [7:0] m, input logic [7:0] n, input int limit,
                         output int lat, output logic [1:0] st, output int rises,
                         output int hi, output int first_rise, output int rdy_hi,
                         output bit to);
    int  k;
    logic pt;
    lat = -1; st = 2'bxx; rises = 0; hi = 0; first_rise = -1; rdy_hi = 0; to = 1'b0;
    pt = 1'b0;
    @(negedge clk);
    valid = 1'b1; mult = m; div = n;
    k = 0;
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      to = 1'b1;
      valid = 1'b0;
      return;
    end
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      if (trig) begin
        hi++;
        if (!pt) begin
          rises++;
          if (first_rise < 0) first_rise = c;
        end
      end
      pt = trig;
      if (ready) rdy_hi++;
      if (resp_valid) begin
        lat = c;
        st  = status;
        return;
      end
    end
    to = 1'b1;
  endtask

  initial begin
    int lat, rises, hi, fr, rdy;
    logic [1:0] st;
    bit to;
    int nresp, r1c, rcnt, pulses;

    rst = 1'b1; valid = 1'b0; mult = 8'd0; div = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_trigger", 32'(trig), 32'd0);
    chk("rst_pll_mult", 32'(pll_mult), 32'd1);
    chk("rst_pll_div", 32'(pll_div), 32'd1);
    chk("rst_cur_mult", 32'(cur_mult), 32'd1);
    chk("rst_cur_div", 32'(cur_div), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Bad arguments: M=0
    run_req(8'd0, 8'd8, 20, lat, st, rises, hi, fr, rdy, to);
    chk("bad_timeout", 32'(to), 32'd0);
    chk("bad_latency", 32'(lat), 32'd2);
    chk("bad_status", 32'(st), 32'd1);
    chk("bad_trig_rises", 32'(rises), 32'd0);
    chk("bad_pll_mult", 32'(pll_mult), 32'd1);
    chk("bad_pll_div", 32'(pll_div), 32'd1);
    repeat (3) @(negedge clk);
    chk("status_hold", 32'(status), 32'd1);
    chk("no_extra_resp", 32'(resp_valid), 32'd0);

    // Nominal OK, lock steady, busy 20 cycles
    busy_en = 1'b1; busy_len = 20; lock_mode = 0;
    run_req(8'd6, 8'd3, 300, lat, st, rises, hi, fr, rdy, to);
    chk("ok_timeout", 32'(to), 32'd0);
    chk("ok_status", 32'(st), 32'd0);
    chk("ok_trig_rises", 32'(rises), 32'd1);
    chk("ok_trig_width", 32'(hi), 32'd5);
    chk("ok_trig_rise_cycle", 32'(fr), 32'd4);
    chk("ok_ready_low", 32'(rdy), 32'd0);
    chk("ok_cur_mult", 32'(cur_mult), 32'd6);
    chk("ok_cur_div", 32'(cur_div), 32'd3);

    // Lock lost during busy and regained at busy fall: 2+2+5+20+2+16 = 47
    lock_mode = 1;
    run_req(8'd7, 8'd5, 300, lat, st, rises, hi, fr, rdy, to);
    chk("lock_timeout_flag", 32'(to), 32'd0);
    chk("relock_latency", 32'(lat), 32'd47);
    chk("relock_status", 32'(st), 32'd0);
    chk("relock_cur_mult", 32'(cur_mult), 32'd7);
    chk("relock_cur_div", 32'(cur_div), 32'd5);

    // Busy never rises: trigger falls at cycle 9, response 64 cycles later
    busy_en = 1'b0; lock_mode = 0;
    run_req(8'd20, 8'd2, 300, lat, st, rises, hi, fr, rdy, to);
    chk("bto_timeout_flag", 32'(to), 32'd0);
    chk("bto_latency", 32'(lat), 32'd73);
    chk("bto_status", 32'(st), 32'd2);
    chk("bto_trig_rises", 32'(rises), 32'd1);
    chk("bto_pll_mult", 32'(pll_mult), 32'd20);
    chk("bto_pll_div", 32'(pll_div), 32'd2);
    chk("bto_cur_mult", 32'(cur_mult), 32'd7);
    chk("bto_cur_div", 32'(cur_div), 32'd5);

    // Lock toggling every 10 cycles never qualifies: 1 try + 2 retries
    busy_en = 1'b1; busy_len = 4; lock_mode = 2;
    run_req(8'd2, 8'd20, 20000, lat, st, rises, hi, fr, rdy, to);
    chk("lto_timeout_flag", 32'(to), 32'd0);
    chk("lto_status", 32'(st), 32'd3);
    chk("lto_trig_rises", 32'(rises), 32'd3);
    chk("lto_trig_cycles", 32'(hi), 32'd15);
    chk("lto_pll_mult", 32'(pll_mult), 32'd2);
    chk("lto_pll_div", 32'(pll_div), 32'd20);
    chk("lto_cur_mult", 32'(cur_mult), 32'd7);
    chk("lto_ready_low", 32'(rdy), 32'd0);

    // Reset during the third trigger-high cycle
    lock_mode = 0; busy_len = 5;
    @(negedge clk);
    valid = 1'b1; mult = 8'd9; div = 8'd9;
    rcnt = 0;
    while (!ready && rcnt < 50) begin
      @(negedge clk);
      rcnt++;
    end
    hi = 0; rcnt = 0;
    while (hi < 3 && rcnt < 20) begin
      @(negedge clk);
      valid = 1'b0;
      rcnt++;
      if (trig) hi++;
    end
    chk("rst_mid_reached_trig", 32'(hi), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_trigger", 32'(trig), 32'd0);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    chk("rst_mid_pll_mult", 32'(pll_mult), 32'd1);
    chk("rst_mid_cur_mult", 32'(cur_mult), 32'd1);
    rst = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("rst_mid_ready_back", 32'(ready), 32'd1);
      if (resp_valid) pulses++;
    end
    chk("rst_mid_no_resp", 32'(pulses), 32'd0);
    chk("rst_mid_status", 32'(status), 32'd0);

    // Back-to-back with valid held high: 8/8 then 6/3
    busy_len = 5;
    valid = 1'b1; mult = 8'd8; div = 8'd8;
    rcnt = 0;
    while (!ready && rcnt < 50) begin
      @(negedge clk);
      rcnt++;
    end
    nresp = 0; r1c = -10; rcnt = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mult = 8'd6; div = 8'd3;
      end
      if (c == r1c + 1) chk("b2b_ready_after_resp", 32'(ready), 32'd1);
      if (ready) rcnt++;
      if (resp_valid) begin
        nresp++;
        chk("b2b_ready_at_resp", 32'(ready), 32'd0);
        chk("b2b_status", 32'(status), 32'd0);
        if (nresp == 1) begin
          r1c = c;
          chk("b2b_first_cur_mult", 32'(cur_mult), 32'd8);
          chk("b2b_first_cur_div", 32'(cur_div), 32'd8);
        end else begin
          chk("b2b_second_cur_mult", 32'(cur_mult), 32'd6);
          chk("b2b_second_cur_div", 32'(cur_div), 32'd3);
          valid = 1'b0;
          break;
        end
      end
    end
    chk("b2b_resp_count", 32'(nresp), 32'd2);
    chk("b2b_ready_cycles", 32'(rcnt), 32'd1);
    repeat (3) @(negedge clk);
    chk("b2b_no_third", 32'(resp_valid), 32'd0);
    chk("b2b_trigger_idle", 32'(trig), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
